// File: rtl/matmul_pkg.sv
// Shared types and default sizing for the matrix_loader / matrix_multiplier pair.
// Both blocks take their default N and DATA_WIDTH from here so they cannot drift apart.
package matmul_pkg;

  localparam int DEFAULT_N          = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    LOAD_A    = 2'd0,
    LOAD_B    = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } loader_state_t;

endpackage

// File: rtl/mat_index_counter.sv
// Row-major (row, col) walker over an N x N matrix, shared by both load phases.
// wrap flags the last element (N-1, N-1); the following inc returns to (0, 0).
module mat_index_counter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [$clog2(N)-1:0] row,
  output logic [$clog2(N)-1:0] col,
  output logic                 wrap
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic row_last;
  logic col_last;

  assign row_last = (row == LAST_IDX);
  assign col_last = (col == LAST_IDX);
  assign wrap     = row_last && col_last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Assembles operand matrices A then B from a valid/ready element stream, hands
// them to matrix_multiplier with a start pulse and holds them until mm_done.
module matrix_loader
  import matmul_pkg::*;
#(
  parameter int N          = DEFAULT_N,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  output logic                                 in_ready,
  input  logic                                 abort,
  input  logic                                 mm_done,
  output logic [N-1:0][N-1:0][DATA_WIDTH-1:0]  A,
  output logic [N-1:0][N-1:0][DATA_WIDTH-1:0]  B,
  output logic                                 start,
  output logic                                 busy,
  output logic                                 frame_err,
  output logic [15:0]                          frame_count
);

  localparam int IDX_W = $clog2(N);

  loader_state_t    state_q, state_d;
  logic [IDX_W-1:0] row, col;
  logic             wrap;
  logic             cnt_inc, cnt_clr;
  logic             err_d;
  logic             frame_done;
  logic             loading;
  logic             accept;
  logic             wr_a, wr_b;

  mat_index_counter #(.N(N)) u_index (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .row     (row),
    .col     (col),
    .wrap    (wrap)
  );

  assign loading = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign accept  = in_valid && in_ready;
  // abort wins over a coincident beat, so that beat is never written
  assign wr_a    = accept && !abort && (state_q == LOAD_A);
  assign wr_b    = accept && !abort && (state_q == LOAD_B);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= LOAD_A;
    else          state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    err_d      = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      LOAD_A, LOAD_B: begin
        if (abort) begin
          state_d = LOAD_A;
          cnt_clr = 1'b1;
        end else if (accept) begin
          cnt_inc = 1'b1;
          if ((state_q == LOAD_B) && wrap) begin
            // final B element: hand off even if in_last was missing
            state_d = START;
            err_d   = !in_last;
          end else if (in_last) begin
            state_d = LOAD_A;
            cnt_clr = 1'b1;
            err_d   = 1'b1;
          end else if (wrap) begin
            state_d = LOAD_B;
          end
        end
      end
      START: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (mm_done) begin
          state_d    = LOAD_A;
          frame_done = 1'b1;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  // in_ready is held low for as long as reset is asserted
  always_comb begin
    in_ready = reset_n && loading;
    start    = (state_q == START);
    busy     = (state_q == START) || (state_q == WAIT_DONE);
  end

  // NOTE: the operand arrays are reset because the multiplier-facing outputs
  // must read zero out of reset; pure storage would normally skip the reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      A <= '0;
      B <= '0;
    end else begin
      if (wr_a) A[row][col] <= in_data;
      if (wr_b) B[row][col] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_err <= err_d;
      if (frame_done) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: a beat-indexed reference model is
// compared against every DUT output on each falling clock edge.
module tb_matrix_loader;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int NN = N * N;

  localparam int M_LOAD  = 0;
  localparam int M_START = 1;
  localparam int M_WAIT  = 2;

  logic                         clk = 1'b0;
  logic                         reset_n;
  logic [DW-1:0]                in_data;
  logic                         in_valid;
  logic                         in_last;
  logic                         in_ready;
  logic                         abort;
  logic                         mm_done;
  logic [N-1:0][N-1:0][DW-1:0]  dut_a;
  logic [N-1:0][N-1:0][DW-1:0]  dut_b;
  logic                         start;
  logic                         busy;
  logic                         frame_err;
  logic [15:0]                  frame_count;

  int checks   = 0;
  int failures = 0;

  matrix_loader #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .abort       (abort),
    .mm_done     (mm_done),
    .A           (dut_a),
    .B           (dut_b),
    .start       (start),
    .busy        (busy),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is just beats 0..2*NN-1; beat k lands in A (k<NN)
  // or B (k>=NN) at row-major position k mod NN.
  int                           m_mode;
  int                           m_k;
  logic                         m_err;
  logic [15:0]                  m_cnt;
  logic [N-1:0][N-1:0][DW-1:0]  m_a;
  logic [N-1:0][N-1:0][DW-1:0]  m_b;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= M_LOAD;
      m_k    <= 0;
      m_err  <= 1'b0;
      m_cnt  <= '0;
      m_a    <= '0;
      m_b    <= '0;
    end else begin
      m_err <= 1'b0;
      if (m_mode == M_LOAD) begin
        if (abort) begin
          m_k <= 0;
        end else if (in_valid) begin
          if (m_k < NN) m_a[m_k / N][m_k % N] <= in_data;
          else          m_b[(m_k - NN) / N][(m_k - NN) % N] <= in_data;
          if (m_k == 2 * NN - 1) begin
            m_mode <= M_START;
            m_k    <= 0;
            m_err  <= !in_last;
          end else if (in_last) begin
            m_k   <= 0;
            m_err <= 1'b1;
          end else begin
            m_k <= m_k + 1;
          end
        end
      end else if (m_mode == M_START) begin
        m_mode <= M_WAIT;
      end else if (mm_done) begin
        m_mode <= M_LOAD;
        m_cnt  <= m_cnt + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready",    in_ready,    reset_n && (m_mode == M_LOAD));
    check("start",       start,       m_mode == M_START);
    check("busy",        busy,        m_mode != M_LOAD);
    check("frame_err",   frame_err,   m_err);
    check("frame_count", frame_count, m_cnt);
    check("A",           dut_a,       m_a);
    check("B",           dut_b,       m_b);
  end

  // Test frame: A = 1..16 row-major, B = identity.
  function automatic logic [DW-1:0] elem(input int k);
    int j;
    if (k < NN) return DW'(k + 1);
    j = k - NN;
    return ((j / N) == (j % N)) ? DW'(1) : DW'(0);
  endfunction

  task automatic send(input logic [DW-1:0] d, input bit last, input bit rnd);
    bit acc;
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? d : DW'($urandom);
      in_last  = last;
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) break;
      guard++;
      if (guard > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready not seen within 200 cycles");
        break;
      end
    end
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    mm_done = 1'b1;
    @(negedge clk);
    mm_done = 1'b0;
  endtask

  task automatic full_frame(input bit rnd);
    for (int k = 0; k < 2 * NN; k++) send(elem(k), k == 2 * NN - 1, rnd);
    idle_inputs();
  endtask

  logic [DW-1:0] rdata [2*NN];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    abort    = 1'b0;
    mm_done  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready",    in_ready,    1'b0);
    check("rst_busy",        busy,        1'b0);
    check("rst_frame_count", frame_count, 16'd0);
    check("rst_A",           dut_a,       '0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: directed frame, in_valid held high
    for (int k = 0; k < 2 * NN; k++) send(elem(k), k == 2 * NN - 1, 1'b0);
    idle_inputs();
    #1;
    check("t1_start_latency", start,        1'b1);
    check("t1_busy",          busy,         1'b1);
    check("t1_a12",           dut_a[1][2],  8'd7);
    check("t1_b33",           dut_b[3][3],  8'd1);
    check("t1_b32",           dut_b[3][2],  8'd0);
    check("t1_model_a12",     m_a[1][2],    8'd7);
    check("t1_model_b33",     m_b[3][3],    8'd1);
    repeat (9) @(negedge clk);
    check("t1_still_busy", busy, 1'b1);
    pulse_done();
    #1;
    check("t1_frame_count", frame_count, 16'd1);
    check("t1_ready_again", in_ready,    1'b1);

    // 2: same frame, random valid gaps
    full_frame(1'b1);
    #1;
    check("t2_a12", dut_a[1][2], 8'd7);
    check("t2_b00", dut_b[0][0], 8'd1);
    pulse_done();

    // 3: early in_last on beat 20, then a clean frame
    for (int k = 0; k < 20; k++) send(elem(k), k == 19, 1'b0);
    idle_inputs();
    #1;
    check("t3_frame_err", frame_err, 1'b1);
    check("t3_no_start",  start,     1'b0);
    check("t3_ready",     in_ready,  1'b1);
    full_frame(1'b0);
    #1;
    check("t3_start", start, 1'b1);
    pulse_done();
    #1;
    check("t3_frame_count", frame_count, 16'd3);

    // 4: abort on beat 10 drops that beat; next 32 beats start from (0,0)
    for (int k = 0; k < 9; k++) send(elem(k), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    in_last  = 1'b0;
    abort    = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 2 * NN; k++) rdata[k] = DW'($urandom);
    for (int k = 0; k < 2 * NN; k++) send(rdata[k], k == 2 * NN - 1, 1'b1);
    idle_inputs();
    #1;
    check("t4_a00",  dut_a[0][0], rdata[0]);
    check("t4_a21",  dut_a[2][1], rdata[9]);
    check("t4_b33",  dut_b[3][3], rdata[2*NN-1]);
    check("t4_start", start,      1'b1);
    pulse_done();

    // random frames with random data and gaps
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 2 * NN; k++) send(DW'($urandom), k == 2 * NN - 1, 1'b1);
      idle_inputs();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      pulse_done();
    end

    // 5: stray mm_done in LOAD_A, then a long wait for done
    pulse_done();
    #1;
    check("t5_stray_done_count", frame_count, 16'd7);
    check("t5_stray_done_ready", in_ready,    1'b1);
    full_frame(1'b1);
    repeat (100) @(negedge clk);
    #1;
    check("t5_busy_held",  busy,        1'b1);
    check("t5_ready_low",  in_ready,    1'b0);
    check("t5_count_held", frame_count, 16'd7);

    // 6: asynchronous reset mid WAIT_DONE
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_busy",     busy,        1'b0);
    check("t6_ready",    in_ready,    1'b0);
    check("t6_count",    frame_count, 16'd0);
    check("t6_A",        dut_a,       '0);
    check("t6_B",        dut_b,       '0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("t6_ready_after", in_ready, 1'b1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Upstream stage of matrix_multiplier.
- Accepts a serial stream of DATA_WIDTH elements over a valid/ready handshake and assembles operand matrices A and B, each row-major.
- Pulses start to the multiplier, holds A/B stable until the multiplier reports done, then re-arms for the next frame.
- Frame: N*N elements of A, followed immediately by N*N elements of B; in_last marks the final B element.

Parameters:
N, 4, matrix dimension; legal range 2..256
DATA_WIDTH, 8, element width; must match matrix_multiplier

Ports:
clk  input  1  system clock
reset_n  input  1  reset (one clock; reset is asynchronous and active-low)
in_data  input  DATA_WIDTH  stream element
in_valid  input  1  in_data valid
in_last  input  1  marks final element of frame (last B element)
in_ready  output  1  loader can accept an element
abort  input  1  synchronous frame discard
mm_done  input  1  done pulse from matrix_multiplier
A  output  DATA_WIDTH x [N][N]  operand A to multiplier
B  output  DATA_WIDTH x [N][N]  operand B to multiplier
start  output  1  one-cycle start pulse to multiplier
busy  output  1  frame handed off, waiting for mm_done
frame_err  output  1  one-cycle pulse on framing error
frame_count  output  16  completed frames, wraps at 2^16

Behaviour:
- Reset (async, reset_n low): state LOAD_A; row/col/sel counters 0; A, B all zero; in_ready=0 while reset_n is low; start=0, busy=0, frame_err=0, frame_count=0.
- States: LOAD_A, LOAD_B, START, WAIT_DONE. State encoding is loader_state_t.
- Accept: a beat is accepted when in_valid && in_ready.
  - in_ready=1 only in LOAD_A and LOAD_B.
  - An accepted element is written at the same clock edge into A[row][col] (LOAD_A) or B[row][col] (LOAD_B).
  - col increments; on col==N-1, col wraps to 0 and row increments.
  - On row==N-1 && col==N-1, row wraps to 0.
- Transitions:
  - LOAD_A -> LOAD_B on accept of element (N-1,N-1).
  - LOAD_B -> START on accept of element (N-1,N-1).
  - START -> WAIT_DONE unconditionally after 1 cycle. start=1 only in START.
  - WAIT_DONE -> LOAD_A on the cycle mm_done is sampled high; frame_count increments on the same edge.
- busy=1 in START and WAIT_DONE.
- A and B are not written in START or WAIT_DONE, so they are stable for the whole multiply.
- Latency: start asserts exactly 1 cycle after the final B element is accepted.
- Early in_last: in_last on an accepted beat that is not the final B element. That element is still written. frame_err pulses the next cycle. State -> LOAD_A, counters -> 0, no start. Contents of A/B are don't-care until reloaded.
- Missing in_last on the final B element: frame_err pulses the next cycle (coincident with start). The frame proceeds normally.
- abort in LOAD_A/LOAD_B: the next state is LOAD_A with counters 0, and any beat on that cycle is discarded (not written).
- abort has priority over the accept on the same cycle. abort is ignored in START and WAIT_DONE.
- mm_done outside WAIT_DONE is ignored.
- Reset mid-operation (any state): immediate return to reset values. The multiplier is reset by its own reset.
- No combinational path from in_valid to in_ready; in_ready depends on state only.

Decomposition:
- matmul_pkg holds loader_state_t (2-bit enum) and the shared default DATA_WIDTH/N constants used by both matrix_loader and matrix_multiplier.
- One sub-module: mat_index_counter (parameter N). Inputs: inc, clr. Outputs: row, col, and wrap (the last-element flag). It is instantiated once and shared by both LOAD states.

Test Plan:
- N=4, stream A=1..16, B=identity with in_last on the 32nd beat, in_valid held high -> in_ready high for 32 cycles. start pulses 1 cycle after the last beat. A[1][2]=7, B[3][3]=1, busy=1. An mm_done pulse 10 cycles later -> LOAD_A and frame_count=1.
- Same frame with in_valid toggled randomly -> identical A/B contents; no element written while in_valid=0.
- in_last on beat 20 -> frame_err pulse next cycle, no start. The following correct 32-beat frame loads and starts normally.
- abort asserted with in_valid on beat 10 -> beat dropped, counters 0. The next 32 beats fill A/B from (0,0).
- mm_done pulsed during LOAD_A, then start in WAIT_DONE with mm_done held low 100 cycles -> in_ready stays 0, busy stays 1, frame_count unchanged.
- reset_n dropped asynchronously mid-WAIT_DONE -> all outputs zero immediately. After release, in_ready=1 in LOAD_A.
